// File: rtl/master_read_ctrl.sv
// Master-side read controller: pops the return FIFO and hides its one-cycle
// read latency behind a 2-entry ring that feeds a valid/ready byte stream.
module master_read_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              idle
);

    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              inflight;
    logic              head;
    logic              tail;
    logic              accept;
    logic              room;
    logic [DATA_W-1:0] mem [0:1];

    assign rd_valid = (occ != 2'd0);
    assign rd_data  = mem[head];
    assign accept   = rd_valid && rd_ready;
    assign idle     = (occ == 2'd0) && !inflight;
    assign tail     = head ^ occ[0];

    // Room counts the in-flight byte so the ring can never overflow.
    assign room = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;

    assign fifo_r_en = !reset && enable && !flush && !fifo_empty
                       && (room || accept);

    always_comb begin
        occ_nxt = occ;
        unique case ({inflight, accept})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            rd_count <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else if (flush) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            rd_count <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= fifo_r_en;
            if (inflight) begin
                mem[tail] <= fifo_data;
            end
            if (accept) begin
                head     <= ~head;
                rd_count <= rd_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_master_read_ctrl.sv
// Scoreboard bench for master_read_ctrl: a FIFO model feeds popped bytes into
// an expected queue that a negedge monitor drains on every accept.
module tb_master_read_ctrl;

    logic        clk_master = 1'b0;
    logic        reset      = 1'b1;
    logic        enable     = 1'b0;
    logic        flush      = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data  = 8'h00;
    logic        rd_ready   = 1'b0;
    logic        fifo_r_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [15:0] rd_count;
    logic        idle;

    logic [7:0]  src[$];
    logic [7:0]  expq[$];
    bit          pop_next;
    bit          last_pop;
    bit          acc;
    bit          gen_tog;
    logic [15:0] mcount;
    int          checks;
    int          passes;
    int          cyc;
    int          first_pop;
    int          first_valid;
    int          pop_cnt;
    int          gen_left;

    master_read_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_master (clk_master),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_count   (rd_count),
        .idle       (idle)
    );

    always #5 clk_master = ~clk_master;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      n, a, e, cyc);
    endtask

    // Monitor: at negedge the expected queue holds buffered plus in-flight bytes.
    always @(negedge clk_master) begin
        cyc++;
        if (reset) begin
            chk("rst_r_en", fifo_r_en, 0);
            chk("rst_valid", rd_valid, 0);
            chk("rst_data", rd_data, 0);
            chk("rst_count", rd_count, 0);
            chk("rst_idle", idle, 1);
            pop_next = 0;
        end else begin
            acc = rd_valid && rd_ready;
            chk("rd_valid", rd_valid, expq.size() > int'(last_pop));
            chk("idle", idle, expq.size() == 0);
            chk("rd_count", rd_count, mcount);
            chk("fifo_r_en", fifo_r_en, enable && !flush && !fifo_empty
                && (expq.size() < 2 || acc));
            if (fifo_r_en) begin
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (acc) begin
                if (expq.size() > 0) chk("rd_data", rd_data, expq.pop_front());
                if (!flush) mcount++;
            end
            if (flush) begin
                expq.delete();
                mcount = 0;
            end
            pop_next = fifo_r_en;
        end
    end

    // One cycle: complete the FIFO's registered read, then drive new inputs.
    task automatic tick(input bit r, input bit e, input bit s, input bit f);
        logic [7:0] b;
        @(posedge clk_master);
        #1;
        if (pop_next) begin
            chk("underflow", src.size() > 0, 1);
            b = (src.size() > 0) ? src.pop_front() : 8'h00;
            fifo_data = b;
            expq.push_back(b);
            last_pop = 1;
        end else begin
            fifo_data = 8'($urandom);
            last_pop = 0;
        end
        if (gen_left > 0 && src.size() < 3) begin
            src.push_back(gen_tog ? 8'hAA : 8'h55);
            gen_tog = !gen_tog;
            gen_left--;
        end
        rd_ready   = r;
        enable     = e;
        flush      = f;
        fifo_empty = s || (src.size() == 0);
    endtask

    task automatic apply_reset();
        @(posedge clk_master);
        #3;
        reset      = 1;
        enable     = 0;
        rd_ready   = 0;
        flush      = 0;
        fifo_empty = 1;
        src.delete();
        expq.delete();
        last_pop = 0;
        pop_next = 0;
        mcount   = 0;
        repeat (2) @(posedge clk_master);
        #1 reset = 0;
    endtask

    initial begin
        int n;
        checks = 0; passes = 0; cyc = 0; mcount = 0;
        gen_left = 0; gen_tog = 0;
        apply_reset();

        // In-order streaming and pop-to-valid latency
        src = '{8'h11, 8'h22, 8'h33};
        first_pop = -1; first_valid = -1;
        repeat (8) tick(1, 1, 0, 0);
        chk("latency", first_valid - first_pop, 2);
        chk("t1_count", rd_count, 3);
        chk("t1_idle", idle, 1);

        // Backpressure: two pops then hold
        apply_reset();
        src = '{8'h11, 8'h22, 8'h33};
        pop_cnt = 0;
        repeat (6) tick(0, 1, 0, 0);
        chk("bp_pops", pop_cnt, 2);
        chk("bp_hold", rd_data, 8'h11);
        chk("bp_valid", rd_valid, 1);
        repeat (6) tick(1, 1, 0, 0);
        chk("bp_count", rd_count, 3);
        chk("bp_idle", idle, 1);

        // Empty FIFO: nothing pops
        pop_cnt = 0;
        repeat (5) tick(1, 1, 0, 0);
        chk("empty_pops", pop_cnt, 0);
        chk("empty_idle", idle, 1);

        // Flush with a byte in flight
        src = '{8'hA5};
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 1);
        tick(1, 1, 0, 0);
        chk("fl_idle", idle, 1);
        chk("fl_valid", rd_valid, 0);
        chk("fl_count", rd_count, 0);
        repeat (4) tick(1, 1, 0, 0);

        // Counter wrap with an alternating stream
        gen_left = 65535;
        n = 0;
        while (mcount != 16'hFFFF && n < 70000) begin
            tick(1, 1, 0, 0);
            n++;
        end
        chk("pre_wrap", rd_count, 16'hFFFF);
        gen_left = 1;
        repeat (6) tick(1, 1, 0, 0);
        chk("wrap", rd_count, 0);
        chk("wrap_idle", idle, 1);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) apply_reset();
            if ($urandom_range(2) == 0 && src.size() < 8)
                src.push_back(8'($urandom));
            tick($urandom_range(3) != 0, $urandom_range(7) != 0,
                 $urandom_range(3) == 0, $urandom_range(59) == 0);
        end
        repeat (30) tick(1, 1, 0, 0);
        chk("rand_idle", idle, 1);
        chk("rand_src", src.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/master_read_ctrl.md
# master_read_ctrl

Read-side controller for the master's return path: it pops bytes from the memory-to-master asynchronous FIFO on the FIFO's read port, in the clk_master domain. It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer and presents the bytes to master logic on a valid/ready stream. It also keeps a running count of delivered bytes.

## Interface
- DATA_W, 8, width of FIFO data and output stream
- CNT_W, 16, width of delivered-byte counter
- clk_master  in  1  master clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clock is clk_master
- enable  in  1  permits new FIFO pops when high
- flush  in  1  synchronous; discards buffered and in-flight data
- fifo_empty  in  1  FIFO empty flag, already in clk_master domain
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_r_en
- fifo_r_en  out  1  FIFO pop strobe, combinational from registered state and inputs
- rd_data  out  DATA_W  head-of-buffer byte
- rd_valid  out  1  rd_data holds a valid byte
- rd_ready  in  1  consumer accepts rd_data this cycle
- rd_count  out  CNT_W  number of bytes accepted since reset or flush
- idle  out  1  buffer empty and no pop in flight

## Operation
- State:
  - occ: buffer occupancy, 0..2.
  - inflight: 1 when a pop was issued last cycle.
  - head pointer into a 2-entry ring.
  - Invariant: occ + inflight <= 2.
- accept = rd_valid && rd_ready.
- Pop rule: fifo_r_en = enable && !flush && !fifo_empty && ((occ + inflight < 2) || accept).
- fifo_r_en is never high while fifo_empty = 1. No underflow is possible.
- Capture: when inflight = 1, fifo_data is written at the tail (head + occ) on that edge.
- Capture and accept in the same cycle leave occ unchanged.
- rd_valid = (occ != 0); rd_data = entry[head].
- Bytes leave in FIFO order. rd_data is stable while rd_valid && !rd_ready.
- On accept, head toggles and rd_count increments. The count wraps from 2^CNT_W-1 to 0.
- enable low: no new pops. An in-flight byte is still captured, and buffered bytes still drain.
- flush high, at the next edge:
  - occ = 0, inflight = 0, and head = 0.
  - rd_count = 0.
  - Any in-flight byte is dropped.
  - fifo_r_en is forced low in the flush cycle.
  - An accept in the flush cycle is not counted.
- idle = (occ == 0) && !inflight.

## Timing
- Reset values: fifo_r_en 0, rd_valid 0, rd_data 0, rd_count 0, idle 1. Buffer entries are cleared to 0.
- Pop-to-output latency: fifo_r_en high in cycle N, fifo_data captured at the end of N+1, rd_valid high in N+2.
- Throughput: with rd_ready held high and FIFO non-empty, one byte per cycle after a 2-cycle fill latency, with no bubbles.
- With rd_ready low, at most 2 pops are outstanding (buffered plus in flight). Then fifo_r_en drops until an accept.
- Reset asserted mid-operation clears all state immediately. A FIFO pop issued in the last cycle before reset is lost. This is acceptable because the FIFO is reset by the same signal.
- fifo_empty asserting while inflight = 1: the in-flight byte is still captured, and no further pops occur.

## Test plan
- Reset, then FIFO holds 0x11, 0x22, 0x33, with enable = 1 and rd_ready = 1 -> rd_valid first high 2 cycles after the first fifo_r_en. rd_data is 0x11, 0x22, 0x33 on consecutive cycles. rd_count = 3, and idle returns to 1.
- Same data with rd_ready = 0 -> exactly 2 fifo_r_en pulses, then fifo_r_en stays 0. rd_data holds 0x11. Raising rd_ready drains 0x11, 0x22, 0x33 in order with no duplicates or drops.
- fifo_empty = 1 throughout, with enable = 1 -> fifo_r_en never asserts, rd_valid = 0, idle = 1.
- Pop 0xA5, then assert flush in the cycle the byte is in flight -> 0xA5 never appears on rd_data. occ = 0, rd_count = 0, idle = 1 on the next cycle.
- Preload rd_count = 2^16-1 by delivering 65535 bytes, then deliver one more -> rd_count = 0. The toggling-pattern byte stream matches FIFO order.
- Random rd_ready and fifo_empty patterns with a scoreboard against the FIFO model, plus reset asserted mid-stream -> no underflow pop, no reordering, and all outputs at reset values during reset.
